// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// "slave" is the arbiter's view; "master" is the environment (requesters plus memory).
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_lock;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_lock;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [1:0]        lock_owner;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout,
    output lock_owner
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout,
    input  lock_owner
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for a single-port async-read data memory, with registered read
// return and an owner lock (with idle timeout) for read-modify-write sequences.
module data_memory_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int FIXED_PRIO   = 0,
  parameter int LOCK_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  data_memory_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_OWN0 = 2'b01,
    LOCK_OWN1 = 2'b10
  } lock_state_t;

  lock_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rr_last_reg, rr_last_next;

  logic [1:0]        req, we, lock, gnt, rvalid;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              own;

  assign req      = {bus.r1_req,  bus.r0_req};
  assign we       = {bus.r1_we,   bus.r0_we};
  assign lock     = {bus.r1_lock, bus.r0_lock};
  assign addr[0]  = bus.r0_addr;
  assign addr[1]  = bus.r1_addr;
  assign wdata[0] = bus.r0_wdata;
  assign wdata[1] = bus.r1_wdata;
  assign own      = (state_reg == LOCK_OWN1);

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state_reg)
        LOCK_NONE: begin
          if (req[0] && req[1])
            gnt = (FIXED_PRIO != 0 || rr_last_reg) ? 2'b01 : 2'b10;
          else
            gnt = req;
        end
        LOCK_OWN0: gnt = {1'b0, req[0]};
        LOCK_OWN1: gnt = {req[1], 1'b0};
        default:   gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rr_last_next = rr_last_reg;
    if (gnt[0]) rr_last_next = 1'b0;
    if (gnt[1]) rr_last_next = 1'b1;
    case (state_reg)
      LOCK_NONE: begin
        cnt_next = '0;
        if (gnt[0] && lock[0])      state_next = LOCK_OWN0;
        else if (gnt[1] && lock[1]) state_next = LOCK_OWN1;
      end
      LOCK_OWN0, LOCK_OWN1: begin
        // While locked, the owner's req is its grant, so !gnt[own] is an idle cycle.
        if (gnt[own]) begin
          cnt_next = '0;
          if (!lock[own]) state_next = LOCK_NONE;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = LOCK_NONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = LOCK_NONE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LOCK_NONE;
      cnt_reg     <= '0;
      rr_last_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rr_last_reg <= rr_last_next;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt[0]) begin
      mem_we   = we[0];
      mem_addr = addr[0];
      mem_din  = wdata[0];
    end else if (gnt[1]) begin
      mem_we   = we[1];
      mem_addr = addr[1];
      mem_din  = wdata[1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= gnt[gi] && !we[gi];
          if (gnt[gi] && !we[gi])
            rdata_reg <= bus.mem_dout;
        end
      end

      // A pulse already on the output is masked while reset is held.
      assign rvalid[gi] = rvalid_reg && !rst;
      assign rdata[gi]  = rdata_reg;
    end
  endgenerate

  assign bus.r0_gnt     = gnt[0];
  assign bus.r1_gnt     = gnt[1];
  assign bus.r0_rvalid  = rvalid[0];
  assign bus.r1_rvalid  = rvalid[1];
  assign bus.r0_rdata   = rdata[0];
  assign bus.r1_rdata   = rdata[1];
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_din    = mem_din;
  assign bus.lock_owner = state_reg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table with a read-data scoreboard, plus
// hand-written reset-in-lock and fixed-priority sequences.
module tb_data_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(8)) fp ();

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1), .LOCK_TIMEOUT(16)) dut_fp (
    .clk(clk), .rst(rst), .bus(fp)
  );

  logic [7:0] mem    [0:255];
  logic [7:0] shadow [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h3C;
      shadow[i] = 8'(i) ^ 8'h3C;
    end
  end
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  assign fp.mem_dout = fp.mem_addr ^ 8'hFF;

  typedef struct {
    logic       req0, we0, lock0;
    logic [7:0] addr0, wdata0;
    logic       req1, we1, lock1;
    logic [7:0] addr1, wdata1;
    logic       g0, g1;
    logic [1:0] lo;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] data;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sb[$];
  logic [1:0] exp_rv = 2'b00;
  int         n_pass = 0;
  int         n_total = 0;

  function automatic vec_t mk(logic q0, logic w0, logic [7:0] a0, logic [7:0] d0, logic l0,
                              logic q1, logic w1, logic [7:0] a1, logic [7:0] d1, logic l1,
                              logic g0, logic g1, logic [1:0] lo);
    vec_t v;
    v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0; v.lock0 = l0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1; v.lock1 = l1;
    v.g0 = g0; v.g1 = g1; v.lo = lo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic apply(vec_t v);
    bus.r0_req = v.req0; bus.r0_we = v.we0; bus.r0_addr = v.addr0;
    bus.r0_wdata = v.wdata0; bus.r0_lock = v.lock0;
    bus.r1_req = v.req1; bus.r1_we = v.we1; bus.r1_addr = v.addr1;
    bus.r1_wdata = v.wdata1; bus.r1_lock = v.lock1;
  endtask

  task automatic check_vec(vec_t v, int idx);
    string      t;
    logic       e_we, rv;
    logic [7:0] e_addr, e_din, rd;
    sb_t        item;
    t      = $sformatf("v%0d", idx);
    e_we   = (v.g0 && v.we0) || (v.g1 && v.we1);
    e_addr = v.g0 ? v.addr0  : (v.g1 ? v.addr1  : 8'h00);
    e_din  = v.g0 ? v.wdata0 : (v.g1 ? v.wdata1 : 8'h00);
    chk({t, ".r0_gnt"},     32'(bus.r0_gnt),     32'(v.g0));
    chk({t, ".r1_gnt"},     32'(bus.r1_gnt),     32'(v.g1));
    chk({t, ".mem_we"},     32'(bus.mem_we),     32'(e_we));
    chk({t, ".mem_addr"},   32'(bus.mem_addr),   32'(e_addr));
    chk({t, ".mem_din"},    32'(bus.mem_din),    32'(e_din));
    chk({t, ".lock_owner"}, 32'(bus.lock_owner), 32'(v.lo));
    for (int p = 0; p < 2; p++) begin
      rv = (p == 0) ? bus.r0_rvalid : bus.r1_rvalid;
      rd = (p == 0) ? bus.r0_rdata  : bus.r1_rdata;
      chk($sformatf("%s.r%0d_rvalid", t, p), 32'(rv), 32'(exp_rv[p]));
      if (exp_rv[p] && sb.size() > 0) begin
        item = sb.pop_front();
        chk($sformatf("%s.r%0d_rdata", t, p), 32'(rd), 32'(item.data));
      end
    end
    exp_rv = 2'b00;
    if (v.g0) begin
      if (v.we0) shadow[v.addr0] = v.wdata0;
      else begin item.port = 0; item.data = shadow[v.addr0]; sb.push_back(item); exp_rv[0] = 1'b1; end
    end
    if (v.g1) begin
      if (v.we1) shadow[v.addr1] = v.wdata1;
      else begin item.port = 1; item.data = shadow[v.addr1]; sb.push_back(item); exp_rv[1] = 1'b1; end
    end
  endtask

  initial begin
    vec_t idle;
    int   mism;
    idle = mk(0,0,8'h00,8'h00,0, 0,0,8'h00,8'h00,0, 0,0,2'b00);

    // write then read-back from the other port
    vecs.push_back(mk(1,1,8'h10,8'hA5,0, 0,0,8'h00,8'h00,0, 1,0,2'b00));
    vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h10,8'h00,0, 0,1,2'b00));
    vecs.push_back(idle);
    // round-robin ties
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,8'h11,8'h00,0, 1,0,8'h12,8'h00,0, (i%2)==0, (i%2)==1, 2'b00));
    vecs.push_back(idle);
    // read-modify-write under lock, other port blocked until after release
    vecs.push_back(mk(1,0,8'h20,8'h00,1, 1,0,8'h30,8'h00,0, 1,0,2'b00));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h30,8'h00,0, 0,0,2'b01));
    vecs.push_back(mk(1,1,8'h20,8'h5A,0, 1,0,8'h30,8'h00,0, 1,0,2'b01));
    vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h30,8'h00,0, 0,1,2'b00));
    vecs.push_back(idle);
    // lock timeout, with a mid-way lock refresh that restarts the count
    vecs.push_back(mk(1,0,8'h40,8'h00,1, 0,0,8'h00,8'h00,0, 1,0,2'b00));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h31,8'h00,0, 0,0,2'b01));
    vecs.push_back(mk(1,0,8'h41,8'h00,1, 1,0,8'h31,8'h00,0, 1,0,2'b01));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h31,8'h00,0, 0,0,2'b01));
    vecs.push_back(mk(0,0,8'h00,8'h00,0, 1,0,8'h31,8'h00,0, 0,1,2'b00));
    vecs.push_back(idle);

    apply(idle);
    fp.r0_req = 0; fp.r0_we = 0; fp.r0_addr = 0; fp.r0_wdata = 0; fp.r0_lock = 0;
    fp.r1_req = 0; fp.r1_we = 0; fp.r1_addr = 0; fp.r1_wdata = 0; fp.r1_lock = 0;

    // reset: a pending write request must not be granted or reach memory
    rst = 1'b1;
    bus.r0_req = 1; bus.r0_we = 1; bus.r0_addr = 8'h33; bus.r0_wdata = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst%0d.r0_gnt", i), 32'(bus.r0_gnt), 32'd0);
      chk($sformatf("rst%0d.mem_we", i), 32'(bus.mem_we), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(idle);
    #1;
    chk("post_rst.lock_owner", 32'(bus.lock_owner), 32'd0);
    chk("post_rst.r0_rvalid",  32'(bus.r0_rvalid),  32'd0);
    chk("post_rst.r1_rvalid",  32'(bus.r1_rvalid),  32'd0);
    chk("post_rst.r0_rdata",   32'(bus.r0_rdata),   32'd0);
    chk("post_rst.r1_rdata",   32'(bus.r1_rdata),   32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check_vec(vecs[i], i);
    end

    // reset while port 1 holds the lock and its read return is on the output
    @(negedge clk);
    apply(mk(0,0,8'h00,8'h00,0, 1,0,8'h50,8'h00,1, 0,0,2'b00));
    #1;
    chk("rl.take.r1_gnt", 32'(bus.r1_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.r0_req = 1;
    #1;
    chk("rl.rst.lock_owner", 32'(bus.lock_owner), 32'b10);
    chk("rl.rst.r0_gnt",     32'(bus.r0_gnt),     32'd0);
    chk("rl.rst.r1_gnt",     32'(bus.r1_gnt),     32'd0);
    chk("rl.rst.r1_rvalid",  32'(bus.r1_rvalid),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1,0,8'h60,8'h00,0, 1,0,8'h61,8'h00,0, 0,0,2'b00));
    #1;
    chk("rl.after.lock_owner", 32'(bus.lock_owner), 32'd0);
    chk("rl.after.r1_rvalid",  32'(bus.r1_rvalid),  32'd0);
    chk("rl.after.r1_rdata",   32'(bus.r1_rdata),   32'd0);
    chk("rl.after.r0_gnt",     32'(bus.r0_gnt),     32'd1);
    chk("rl.after.r1_gnt",     32'(bus.r1_gnt),     32'd0);
    @(negedge clk);
    apply(idle);
    #1;
    chk("rl.ret.r0_rvalid", 32'(bus.r0_rvalid), 32'd1);
    chk("rl.ret.r0_rdata",  32'(bus.r0_rdata),  32'(shadow[8'h60]));

    // fixed priority: port 0 wins every tie
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      fp.r0_req = (i < 6); fp.r0_addr = 8'(8'h70 + i);
      fp.r1_req = (i < 6); fp.r1_addr = 8'h7F;
      #1;
      if (i < 6) begin
        chk($sformatf("fp%0d.r0_gnt", i), 32'(fp.r0_gnt), 32'd1);
        chk($sformatf("fp%0d.r1_gnt", i), 32'(fp.r1_gnt), 32'd0);
      end
      if (i > 0) begin
        chk($sformatf("fp%0d.r0_rvalid", i), 32'(fp.r0_rvalid), 32'd1);
        chk($sformatf("fp%0d.r0_rdata", i),  32'(fp.r0_rdata),  32'(8'(8'h70 + i - 1) ^ 8'hFF));
      end
    end

    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== shadow[i]) mism++;
    chk("mem_contents_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the DMA/loader.
- The memory has asynchronous read and a write on the clock edge.
- Block sits between the requesters and the memory. It drives the memory's we/addr/din and samples its dout.
- Provides per-port grant, registered read return and an atomic lock for read-modify-write sequences.

Parameters:
ADDR_W, 8, address width (256 locations)
DATA_W, 8, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties
LOCK_TIMEOUT, 16, idle cycles after which a held lock is force-released (must be >= 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
rN_req  in  1  port N (N = 0,1) transfer request
rN_we  in  1  port N: 1 = write, 0 = read
rN_addr  in  ADDR_W  port N address
rN_wdata  in  DATA_W  port N write data
rN_lock  in  1  port N: keep ownership after this transfer
rN_gnt  out  1  port N transfer accepted this cycle (combinational)
rN_rvalid  out  1  port N read data valid (one-cycle pulse)
rN_rdata  out  DATA_W  port N read data (registered)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data (asynchronous)
lock_owner  out  2  00 none, 01 port 0, 10 port 1 (11 never)

Behaviour:
- Reset (rst=1 at an edge):
  - lock_owner=00; rvalid=0; rdata=0; timeout counter=0.
  - rr_last=port 1, so port 0 wins the first tie.
  - While rst=1, both gnt are forced to 0 and mem_we=0.
- Transfer: occurs in a cycle where rN_req && rN_gnt. Never more than one gnt high.
- Arbitration, combinational each cycle:
  - lock_owner=none, one requester: that requester is granted.
  - lock_owner=none, both requesting: FIXED_PRIO=1 grants port 0; otherwise the port != rr_last is granted.
  - lock_owner=port k: only port k may be granted (gnt_k=req_k); the other port's gnt=0 regardless of its req.
- rr_last updates to the granted port on every transfer, including locked ones.
- Memory drive:
  - Granted port's addr/wdata are muxed onto mem_addr/mem_din; mem_we = gnt && we.
  - No grant: mem_we=0, mem_addr=0, mem_din=0.
  - Write commits at the edge ending the grant cycle.
- Read return:
  - On a read transfer, mem_dout is registered into rN_rdata at the same edge.
  - rN_rvalid=1 for exactly the next cycle.
  - rN_rdata holds its value until the next read by that port.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- Lock state machine (NONE, OWN0, OWN1):
  - NONE -> OWNk on a port-k transfer with rk_lock=1.
  - OWNk -> NONE on a port-k transfer with rk_lock=0. That transfer itself completes normally.
  - OWNk -> OWNk on a port-k transfer with rk_lock=1; the timeout counter clears to 0.
  - In OWNk, each cycle with rk_req=0 increments the counter.
  - Reaching LOCK_TIMEOUT forces NONE at that edge and clears the counter. In the following cycle the other port may be granted.
- Consistency: a write by one port followed next cycle by a read of the same address by either port returns the new data.
- Simultaneous events: lock release by the owner and a req from the other port in the same cycle. The other port is not granted that cycle; it is granted the next cycle.
- rst asserted mid-lock or with an rvalid pending: the lock is dropped and the rvalid pulse is suppressed.

Test Plan:
- Reset, then r0 writes 0xA5 to addr 0x10, then r1 reads 0x10 -> r0_gnt in cycle 1, mem_we=1 in cycle 1; r1_rvalid one cycle after its grant with r1_rdata=0xA5.
- Both ports request reads every cycle for 6 cycles, FIXED_PRIO=0 -> grants alternate 0,1,0,1,0,1; each port's rvalid follows its grant by one cycle. With FIXED_PRIO=1 -> port 0 granted all 6 cycles.
- r0 reads 0x20 with lock=1, r1 requests continuously, r0 writes 0x20 (lock=0) three cycles later -> r1_gnt=0 until the cycle after the r0 write; lock_owner 01 then 00.
- r0 takes the lock, then drops req; r1 requests -> lock_owner returns to 00 after exactly 16 idle cycles; r1_gnt=1 the next cycle.
- rst pulsed for one cycle while lock_owner=10 and a read rvalid is pending -> lock_owner=00, no rvalid, rr_last reset so a following tie grants port 0.
- Neither port requests -> mem_we=0, mem_addr=0, mem_din=0; memory contents at addresses 0x00–0xFF unchanged.
